// File: rtl/pe_row_4.sv
// pe_row_4 -- one row of four multiply/accumulate processing elements.
//
// Operand pairs (i_r, i_f) enter stage 0 and shift one stage per enabled
// clock through a 4-deep chain. Every stage multiplies its operand pair
// combinationally. The four products are summed along the row, and the
// sum is registered into o_psum. As a result, o_psum holds the sum of
// i_r*i_f over the four pairs captured before the current edge. The sum
// wraps modulo 2^(2*WIDTH).
//
// Ports
//   clk    : single clock, rising-edge active
//   rstn   : synchronous active-low reset; clears all stages and o_psum
//   en     : global enable for the stage chain and the output register
//   i_r    : WIDTH-bit unsigned input-activation operand
//   i_f    : WIDTH-bit unsigned filter (weight) operand
//   o_psum : 2*WIDTH-bit unsigned registered row partial sum
module pe_row_4 #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               en,
    input  logic [WIDTH-1:0]   i_r,
    input  logic [WIDTH-1:0]   i_f,
    output logic [2*WIDTH-1:0] o_psum
);

    localparam int PW = 2 * WIDTH;

    logic [WIDTH-1:0] r_p [4];
    logic [WIDTH-1:0] f_p [4];
    logic [PW-1:0]    prod [4];
    logic [PW-1:0]    psum [4];

    // Stage registers -> per-PE products -> chained partial sum
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            prod[k] = {{WIDTH{1'b0}}, r_p[k]} * {{WIDTH{1'b0}}, f_p[k]};
        end
        psum[0] = prod[0];
        for (int k = 1; k < 4; k++) begin
            psum[k] = psum[k-1] + prod[k];
        end
    end

    // Shift chain and output register share one enable, so holding en low
    // freezes the whole row without losing or duplicating any stage.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < 4; k++) begin
                r_p[k] <= '0;
                f_p[k] <= '0;
            end
            o_psum <= '0;
        end else if (en) begin
            r_p[0] <= i_r;
            f_p[0] <= i_f;
            for (int k = 1; k < 4; k++) begin
                r_p[k] <= r_p[k-1];
                f_p[k] <= f_p[k-1];
            end
            o_psum <= psum[3];
        end
    end

endmodule

// File: tb/tb_pe_row_4.sv
// Testbench for pe_row_4 (WIDTH=8).
// The driver applies one input vector per clock. After each edge it pushes
// the expected o_psum into a scoreboard queue. For directed vectors this is
// a hand-computed constant. For random traffic it comes from a 4-deep shift
// and sum model. A separate monitor pops the queue on each falling edge and
// compares against the DUT.
module tb_pe_row_4;

    logic        clk;
    logic        rstn;
    logic        en;
    logic [7:0]  i_r;
    logic [7:0]  i_f;
    logic [15:0] o_psum;

    pe_row_4 #(.WIDTH(8)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .en     (en),
        .i_r    (i_r),
        .i_f    (i_f),
        .o_psum (o_psum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] exp;
    } item_t;

    item_t sb[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    // reference model state
    logic [7:0]  mr [4];
    logic [7:0]  mf [4];
    logic [15:0] mo;

    task automatic model_edge(input logic rn, input logic e,
                              input logic [7:0] a, input logic [7:0] b);
        logic [15:0] s;
        if (!rn) begin
            for (int k = 0; k < 4; k++) begin
                mr[k] = '0;
                mf[k] = '0;
            end
            mo = '0;
        end else if (e) begin
            s = '0;
            for (int k = 0; k < 4; k++) s = s + 16'(mr[k]) * 16'(mf[k]);
            mo = s;
            for (int k = 3; k > 0; k--) begin
                mr[k] = mr[k-1];
                mf[k] = mf[k-1];
            end
            mr[0] = a;
            mf[0] = b;
        end
    endtask

    // Drive one vector, take one edge, push the expected response.
    task automatic step(input logic rn, input logic e,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] hand_exp, input bit use_hand,
                        input string name);
        item_t it;
        rstn = rn;
        en   = e;
        i_r  = a;
        i_f  = b;
        @(posedge clk);
        model_edge(rn, e, a, b);
        it.name = name;
        it.exp  = use_hand ? hand_exp : mo;
        sb.push_back(it);
        #1;
    endtask

    // monitor
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                it = sb.pop_front();
                n_checks++;
                if (o_psum === it.exp) n_pass++;
                else $display("FAIL %s: o_psum=%0d expected=%0d", it.name, o_psum, it.exp);
            end
        end
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    logic [7:0]  br  [8];
    logic [7:0]  bf  [8];
    logic [15:0] bex [8];

    initial begin
        for (int k = 0; k < 4; k++) begin
            mr[k] = '0;
            mf[k] = '0;
        end
        mo = '0;
        br  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
        bf  = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        bex = '{16'd0, 16'd1, 16'd5, 16'd14, 16'd14, 16'd13, 16'd9, 16'd0};

        // reset with random operands and en=1
        for (int i = 0; i < 2; i++)
            step(1'b0, 1'b1, 8'($urandom), 8'($urandom), 16'd0, 1'b1, "reset");
        // zero inputs after release: stages must have been cleared
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 8'd0, 8'd0, 16'd0, 1'b1, "post_reset");

        // basic stream
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b1, br[i], bf[i], bex[i], 1'b1, "basic");

        // enable hold
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, br[i], bf[i], bex[i], 1'b1, "hold_pre");
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 8'd200, 8'd77, 16'd14, 1'b1, "hold_en0");
        step(1'b1, 1'b1, 8'd0, 8'd0, 16'd14, 1'b1, "hold_resume");
        step(1'b1, 1'b1, 8'd0, 8'd0, 16'd13, 1'b1, "hold_resume");
        step(1'b1, 1'b1, 8'd0, 8'd0, 16'd9,  1'b1, "hold_resume");
        step(1'b1, 1'b1, 8'd0, 8'd0, 16'd0,  1'b1, "hold_resume");

        // overflow wrap
        step(1'b1, 1'b1, 8'd255, 8'd255, 16'd0,     1'b1, "ovf");
        step(1'b1, 1'b1, 8'd255, 8'd255, 16'd65025, 1'b1, "ovf");
        step(1'b1, 1'b1, 8'd255, 8'd255, 16'd64514, 1'b1, "ovf");
        step(1'b1, 1'b1, 8'd255, 8'd255, 16'd64003, 1'b1, "ovf");
        step(1'b1, 1'b1, 8'd0,   8'd0,   16'd63492, 1'b1, "ovf_wrap4");
        step(1'b1, 1'b1, 8'd0,   8'd0,   16'd64003, 1'b1, "ovf_drain");
        step(1'b1, 1'b1, 8'd0,   8'd0,   16'd64514, 1'b1, "ovf_drain");
        step(1'b1, 1'b1, 8'd0,   8'd0,   16'd65025, 1'b1, "ovf_drain");
        step(1'b1, 1'b1, 8'd0,   8'd0,   16'd0,     1'b1, "ovf_drain");

        // mid-stream reset
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, br[i], bf[i], bex[i], 1'b1, "mid_pre");
        step(1'b0, 1'b1, br[3], bf[3], 16'd0, 1'b1, "mid_reset");
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, 8'd0, 8'd0, 16'd0, 1'b1, "mid_after");

        // random traffic, en at ~90% duty
        for (int i = 0; i < 1000; i++)
            step(1'b1, ($urandom_range(9) != 0), 8'($urandom), 8'($urandom),
                 16'd0, 1'b0, "random");

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL drain: pending=%0d expected=0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pe_row_4.md
PE_ROW_4 -- requirements
Module: pe_row_4

Interface
REQ-001 Parameter WIDTH SHALL be provided with default 8 and SHALL set the operand width; the result width is 2*WIDTH.
REQ-002 One clock; reset is synchronous and active-low.
REQ-003 Port clk SHALL be an input, 1 bit, and is the single clock; all state updates occur on its rising edge.
REQ-004 Port rstn SHALL be an input, 1 bit, and is the synchronous active-low reset.
REQ-005 Port en SHALL be an input, 1 bit, and is the global enable for all state (shift stages and output register).
REQ-006 Port i_r SHALL be an input, WIDTH bits, unsigned, and is the input-activation (row) operand stream.
REQ-007 Port i_f SHALL be an input, WIDTH bits, unsigned, and is the filter (weight) operand stream.
REQ-008 Port o_psum SHALL be an output, 2*WIDTH bits, unsigned, and is the registered row partial sum.

Function
REQ-009 The block SHALL contain four PE stages k=0..3, each holding one registered operand pair r[k] and f[k], each WIDTH bits.
REQ-010 On each rising edge with rstn=1 and en=1, stage 0 SHALL capture i_r and i_f.
REQ-011 On the same edge, stage k (k=1..3) SHALL capture the pre-edge contents of stage k-1, forming a 4-deep shift chain.
REQ-012 Each PE SHALL compute the product p[k] = r[k]*f[k] as an unsigned full-width product of 2*WIDTH bits, combinationally from its stage registers.
REQ-013 The partial sum SHALL chain through the PEs: ps[0]=p[0]; ps[k]=ps[k-1]+p[k].
REQ-014 On each rising edge with rstn=1 and en=1, o_psum SHALL load ps[3], which is computed from the pre-edge stage contents.
REQ-015 Latency: a pair presented before edge N SHALL be captured at edge N and SHALL contribute to o_psum values loaded at edges N+1 through N+4 inclusive.
REQ-016 In steady state, o_psum SHALL equal the sum of i_r*i_f over the four most recently captured pairs, excluding the pair captured at the current edge.
REQ-017 Summation SHALL wrap modulo 2^(2*WIDTH), with no saturation and no overflow flag.
REQ-018 With en=0 and rstn=1, all stage registers and o_psum SHALL hold their values, and no new input is captured.
REQ-019 Re-asserting en SHALL resume shifting from the held state with no loss or duplication of stage contents.
REQ-020 No handshake SHALL exist; every enabled edge consumes one pair.

Reset
REQ-021 On a rising edge with rstn=0, all r[k], f[k] and o_psum SHALL become 0, regardless of en.
REQ-022 Reset asserted mid-stream SHALL discard all in-flight pairs, and o_psum SHALL read 0 on the edge following reset.
REQ-023 After reset release, o_psum SHALL remain 0 until the first non-zero product has been captured and one further enabled edge has occurred.

Verification
REQ-024 Reset: hold rstn=0 for 2 edges with random i_r and i_f and en=1 -> o_psum=0 and all stages 0.
REQ-025 Basic stream (WIDTH=8, en=1): pairs (1,1),(2,2),(3,3),(4,0),(0,0),(0,0)... captured at edges N1..N6, ... -> o_psum after edges N1..N8 = 0,1,5,14,14,13,9,0.
REQ-026 Enable hold: run the REQ-025 stream, drop en after edge N4 (o_psum=14) for 3 edges -> o_psum stays 14 and the inputs are ignored; raise en -> sequence resumes with 14,13,9,0.
REQ-027 Overflow: four consecutive pairs (255,255) -> after the 5th edge o_psum = (4*65025) mod 65536 = 63492.
REQ-028 Mid-stream reset: during the REQ-025 stream, assert rstn=0 for 1 edge after N3 -> o_psum=0; with zero inputs afterwards it stays 0.
REQ-029 Random: 1000 cycles of random i_r, i_f and en at 90% duty -> o_psum matches a 4-deep shift and sum reference model every cycle.
